imm_gen_stage: RTL and testbench

- Registered, parametrised immediate-generation stage for the RV decode path.
- Takes a raw instruction over a valid/ready handshake, classifies its format from the opcode, and produces the sign- or zero-extended immediate at XLEN width.
- Handles shift-amount immediates and, optionally, the RVC subset.
- A 2-entry elastic buffer decouples fetch from decode.

---
 rtl/imm_gen_stage.sv | 197 +++++++++++++++++++
 tb/tb_imm_gen_stage.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// Immediate-generation stage: decodes an RV32/RV64 or RVC instruction into its
// format and extended immediate, then queues the result in a 2-entry elastic buffer.
module imm_gen_stage #(
  parameter int XLEN      = 32,
  parameter int SUPPORT_C = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic            out_is_c
);

  localparam logic [2:0] FMT_R     = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // Entry layout: {is_c, illegal, fmt[2:0], imm[XLEN-1:0]}
  localparam int EW = XLEN + 5;

  logic [6:0]        opcode;
  logic [15:0]       ci;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]   dec_imm;
  logic [2:0]        dec_fmt;
  logic              dec_ill;
  logic              dec_is_c;
  logic [EW-1:0]     dec_entry;

  assign opcode = in_instr[6:0];
  assign ci     = in_instr[15:0];

  // Every immediate fits in 32 signed bits, so decode at 32 and widen once.
  always_comb begin
    imm32    = '0;
    dec_fmt  = FMT_R;
    dec_ill  = 1'b0;
    dec_is_c = (in_instr[1:0] != 2'b11);
    if (!dec_is_c) begin
      case (opcode)
        OP_LOAD, OP_JALR, OP_SYSTEM: begin
          dec_fmt = FMT_I;
          imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
        end
        OP_IMM: begin
          if (in_instr[13:12] == 2'b01) begin
            dec_fmt = FMT_SHAMT;
            if (XLEN == 32) begin
              dec_ill = in_instr[25];
              imm32   = {27'b0, in_instr[24:20]};
            end else begin
              imm32   = {26'b0, in_instr[25:20]};
            end
          end else begin
            dec_fmt = FMT_I;
            imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
          end
        end
        OP_STORE: begin
          dec_fmt = FMT_S;
          imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        end
        OP_BRANCH: begin
          dec_fmt = FMT_B;
          imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
        end
        OP_LUI, OP_AUIPC: begin
          dec_fmt = FMT_U;
          imm32   = {in_instr[31:12], 12'b0};
        end
        OP_JAL: begin
          dec_fmt = FMT_J;
          imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
        end
        OP_OP:   dec_fmt = FMT_R;
        default: dec_ill = 1'b1;
      endcase
    end else if (SUPPORT_C != 0) begin
      // Keyed on {quadrant, funct3}
      case ({ci[1:0], ci[15:13]})
        5'b01_000, 5'b01_010: begin
          dec_fmt = FMT_I;
          imm32   = {{26{ci[12]}}, ci[12], ci[6:2]};
        end
        5'b00_010: begin
          dec_fmt = FMT_I;
          imm32   = {25'b0, ci[5], ci[12:10], ci[6], 2'b00};
        end
        5'b00_110: begin
          dec_fmt = FMT_S;
          imm32   = {25'b0, ci[5], ci[12:10], ci[6], 2'b00};
        end
        5'b01_101: begin
          dec_fmt = FMT_J;
          imm32   = {{20{ci[12]}}, ci[12], ci[8], ci[10:9], ci[6], ci[7],
                     ci[2], ci[11], ci[5:3], 1'b0};
        end
        5'b01_110, 5'b01_111: begin
          dec_fmt = FMT_B;
          imm32   = {{23{ci[12]}}, ci[12], ci[6:5], ci[2], ci[11:10], ci[4:3], 1'b0};
        end
        default: dec_ill = 1'b1;
      endcase
    end else begin
      dec_ill = 1'b1;
    end
    if (dec_ill) begin
      imm32   = '0;
      dec_fmt = FMT_R;
    end
  end

  assign dec_imm   = XLEN'(imm32);
  assign dec_entry = {dec_is_c, dec_ill, dec_fmt, dec_imm};

  logic [EW-1:0] slot_q [2];
  logic [EW-1:0] slot_d [2];
  logic [1:0]    count_q, count_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic          push, pop;
  logic [EW-1:0] head;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    slot_d   = slot_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        slot_d[wr_ptr_q] = dec_entry;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        slot_q[k] <= '0;
      end
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Stale slot contents are masked so an empty stage reads as all-zero.
  assign head        = out_valid ? slot_q[rd_ptr_q] : '0;
  assign out_imm     = head[XLEN-1:0];
  assign out_fmt     = head[XLEN+2:XLEN];
  assign out_illegal = head[XLEN+3];
  assign out_is_c    = head[XLEN+4];

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: an RV32+C instance and an RV64-without-C instance
// share one stimulus stream and are checked against a queue-based reference model.
module tb_imm_gen_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;

  logic        a_in_ready, a_out_valid, a_out_illegal, a_out_is_c;
  logic [31:0] a_out_imm;
  logic [2:0]  a_out_fmt;
  logic        b_in_ready, b_out_valid, b_out_illegal, b_out_is_c;
  logic [63:0] b_out_imm;
  logic [2:0]  b_out_fmt;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  imm_gen_stage #(.XLEN(32), .SUPPORT_C(1)) dut_a (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_out_imm),
    .out_fmt(a_out_fmt), .out_illegal(a_out_illegal), .out_is_c(a_out_is_c)
  );

  imm_gen_stage #(.XLEN(64), .SUPPORT_C(0)) dut_b (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_out_imm),
    .out_fmt(b_out_fmt), .out_illegal(b_out_illegal), .out_is_c(b_out_is_c)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference decoder: works from the numeric value of each immediate field.
  function automatic void ref_decode(input logic [31:0] ins, input int xlen, input bit sc,
                                     output logic [63:0] imm, output logic [2:0] fmt,
                                     output bit ill, output bit isc);
    int s;
    int v;
    logic [15:0] c;
    s   = int'(ins);
    c   = ins[15:0];
    v   = 0;
    fmt = 3'd0;
    ill = 1'b0;
    isc = (ins[1:0] != 2'b11);
    if (!isc) begin
      case (ins[6:0])
        7'b0000011, 7'b1100111, 7'b1110011: begin fmt = 3'd1; v = s >>> 20; end
        7'b0010011: begin
          if (ins[13:12] == 2'b01) begin
            fmt = 3'd6;
            if (xlen == 32) begin
              ill = ins[25];
              v   = int'(ins[24:20]);
            end else begin
              v   = int'(ins[25:20]);
            end
          end else begin
            fmt = 3'd1; v = s >>> 20;
          end
        end
        7'b0100011: begin fmt = 3'd2; v = (s >>> 25) * 32 + int'(ins[11:7]); end
        7'b1100011: begin
          fmt = 3'd3;
          v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
              + int'(ins[11:8]) * 2;
        end
        7'b0110111, 7'b0010111: begin fmt = 3'd4; v = s & ~4095; end
        7'b1101111: begin
          fmt = 3'd5;
          v = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
              + int'(ins[30:21]) * 2;
        end
        7'b0110011: fmt = 3'd0;
        default: ill = 1'b1;
      endcase
    end else if (!sc) begin
      ill = 1'b1;
    end else begin
      case ({c[1:0], c[15:13]})
        5'b01000, 5'b01010: begin fmt = 3'd1; v = int'(c[6:2]) - (c[12] ? 32 : 0); end
        5'b00010, 5'b00110: begin
          fmt = (c[15] ? 3'd2 : 3'd1);
          v = int'(c[5]) * 64 + int'(c[12:10]) * 8 + int'(c[6]) * 4;
        end
        5'b01101: begin
          fmt = 3'd5;
          v = (c[12] ? -2048 : 0) + int'(c[8]) * 1024 + int'(c[10:9]) * 256 + int'(c[6]) * 128
              + int'(c[7]) * 64 + int'(c[2]) * 32 + int'(c[11]) * 16 + int'(c[5:3]) * 2;
        end
        5'b01110, 5'b01111: begin
          fmt = 3'd3;
          v = (c[12] ? -256 : 0) + int'(c[6:5]) * 64 + int'(c[2]) * 32
              + int'(c[11:10]) * 8 + int'(c[4:3]) * 2;
        end
        default: ill = 1'b1;
      endcase
    end
    if (ill) begin
      v   = 0;
      fmt = 3'd0;
    end
    imm = 64'(longint'(v));
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [6:0]  ops [12];
    int          k;
    ops = '{7'b0000011, 7'b0010011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0001111};
    r = $urandom();
    k = $urandom_range(0, 9);
    if (k < 6)      r[6:0] = ops[$urandom_range(0, 11)];
    else if (k < 9) r[1:0] = 2'($urandom_range(0, 2));
    else            r = 32'h0;
    return r;
  endfunction

  task automatic drive(input bit v, input logic [31:0] ins, input bit rdy, input bit fl);
    in_valid  = v;
    in_instr  = ins;
    out_ready = rdy;
    flush     = fl;
    @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = 32'h0;
    repeat (2) @(negedge clock);
    tests_run++;
    if ({a_out_valid, a_in_ready, a_out_imm, a_out_fmt, a_out_illegal, a_out_is_c} !==
        {1'b0, 1'b1, 32'h0, 3'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_a: got v=%b rdy=%b imm=%h fmt=%0d ill=%b c=%b want 0 1 0 0 0 0",
               a_out_valid, a_in_ready, a_out_imm, a_out_fmt, a_out_illegal, a_out_is_c);
    end
    reset = 1'b0;
    @(negedge clock);
    tests_run++;
    if ({b_out_valid, b_in_ready, b_out_imm, b_out_fmt, b_out_illegal, b_out_is_c} !==
        {1'b0, 1'b1, 64'h0, 3'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_b: got v=%b rdy=%b imm=%h fmt=%0d ill=%b want 0 1 0 0 0",
               b_out_valid, b_in_ready, b_out_imm, b_out_fmt, b_out_illegal);
    end
    $display("[TB] reset released, stage empty");
  endtask

  task automatic test_addi;
    drive(1'b1, 32'hFFF00093, 1'b0, 1'b0);
    in_valid = 1'b0;
    tests_run++;
    if ({a_out_valid, a_out_imm, a_out_fmt, a_out_illegal, a_out_is_c} !==
        {1'b1, 32'hFFFFFFFF, 3'd1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL addi_a: got v=%b imm=%h fmt=%0d ill=%b c=%b want 1 ffffffff 1 0 0",
               a_out_valid, a_out_imm, a_out_fmt, a_out_illegal, a_out_is_c);
    end
    tests_run++;
    if ({b_out_valid, b_out_imm, b_out_fmt, b_out_illegal} !==
        {1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL addi_b: got v=%b imm=%h fmt=%0d ill=%b want 1 ffffffffffffffff 1 0",
               b_out_valid, b_out_imm, b_out_fmt, b_out_illegal);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tests_run++;
    if ({a_out_valid, a_in_ready, a_out_imm, a_out_fmt} !== {1'b0, 1'b1, 32'h0, 3'd0}) begin
      tests_failed++;
      $display("FAIL addi_drain: got v=%b rdy=%b imm=%h fmt=%0d want 0 1 0 0",
               a_out_valid, a_in_ready, a_out_imm, a_out_fmt);
    end
    $display("[TB] addi x1,x0,-1 -> a_imm=%h b_imm=%h", 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
  endtask

  task automatic test_store_jump;
    drive(1'b1, 32'hFE112E23, 1'b1, 1'b0);
    in_valid = 1'b0;
    tests_run++;
    if ({a_out_valid, a_out_imm, a_out_fmt, a_out_illegal} !== {1'b1, 32'hFFFFFFFC, 3'd2, 1'b0}) begin
      tests_failed++;
      $display("FAIL sw_a: got v=%b imm=%h fmt=%0d ill=%b want 1 fffffffc 2 0",
               a_out_valid, a_out_imm, a_out_fmt, a_out_illegal);
    end
    drive(1'b1, 32'hFF9FF06F, 1'b1, 1'b0);
    in_valid = 1'b0;
    tests_run++;
    if ({a_out_valid, a_out_imm, a_out_fmt, a_out_illegal} !== {1'b1, 32'hFFFFFFF8, 3'd5, 1'b0}) begin
      tests_failed++;
      $display("FAIL j_a: got v=%b imm=%h fmt=%0d ill=%b want 1 fffffff8 5 0",
               a_out_valid, a_out_imm, a_out_fmt, a_out_illegal);
    end
    tests_run++;
    if ({b_out_imm, b_out_fmt} !== {64'hFFFFFFFFFFFFFFF8, 3'd5}) begin
      tests_failed++;
      $display("FAIL j_b: got imm=%h fmt=%0d want fffffffffffffff8 5", b_out_imm, b_out_fmt);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    $display("[TB] sw -4 and j -8 decoded");
  endtask

  task automatic test_backpressure;
    drive(1'b1, 32'hFFF00093, 1'b0, 1'b0);
    in_instr = 32'hFE112E23;
    tests_run++;
    if ({a_out_valid, a_in_ready, a_out_imm} !== {1'b1, 1'b1, 32'hFFFFFFFF}) begin
      tests_failed++;
      $display("FAIL bp_one: got v=%b rdy=%b imm=%h want 1 1 ffffffff",
               a_out_valid, a_in_ready, a_out_imm);
    end
    @(negedge clock);
    in_instr = 32'hFF9FF06F;
    tests_run++;
    if ({a_in_ready, b_in_ready, a_out_imm} !== {1'b0, 1'b0, 32'hFFFFFFFF}) begin
      tests_failed++;
      $display("FAIL bp_full: got rdy_a=%b rdy_b=%b imm=%h want 0 0 ffffffff",
               a_in_ready, b_in_ready, a_out_imm);
    end
    @(negedge clock);
    tests_run++;
    if ({a_out_valid, a_in_ready, a_out_imm, a_out_fmt} !== {1'b1, 1'b0, 32'hFFFFFFFF, 3'd1}) begin
      tests_failed++;
      $display("FAIL bp_hold: got v=%b rdy=%b imm=%h fmt=%0d want 1 0 ffffffff 1",
               a_out_valid, a_in_ready, a_out_imm, a_out_fmt);
    end
    out_ready = 1'b1;
    @(negedge clock);
    tests_run++;
    if ({a_out_valid, a_in_ready, a_out_imm, a_out_fmt} !== {1'b1, 1'b1, 32'hFFFFFFFC, 3'd2}) begin
      tests_failed++;
      $display("FAIL bp_second: got v=%b rdy=%b imm=%h fmt=%0d want 1 1 fffffffc 2",
               a_out_valid, a_in_ready, a_out_imm, a_out_fmt);
    end
    @(negedge clock);
    in_valid = 1'b0;
    tests_run++;
    if ({a_out_valid, a_out_imm, a_out_fmt} !== {1'b1, 32'hFFFFFFF8, 3'd5}) begin
      tests_failed++;
      $display("FAIL bp_third: got v=%b imm=%h fmt=%0d want 1 fffffff8 5",
               a_out_valid, a_out_imm, a_out_fmt);
    end
    @(negedge clock);
    tests_run++;
    if ({a_out_valid, a_in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL bp_empty: got v=%b rdy=%b want 0 1", a_out_valid, a_in_ready);
    end
    $display("[TB] backpressure A,B,C emerged in order");
  endtask

  task automatic test_rvc;
    drive(1'b1, 32'h000010FD, 1'b1, 1'b0);
    in_valid = 1'b0;
    tests_run++;
    if ({a_out_valid, a_out_imm, a_out_fmt, a_out_illegal, a_out_is_c} !==
        {1'b1, 32'hFFFFFFFF, 3'd1, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL caddi_a: got v=%b imm=%h fmt=%0d ill=%b c=%b want 1 ffffffff 1 0 1",
               a_out_valid, a_out_imm, a_out_fmt, a_out_illegal, a_out_is_c);
    end
    tests_run++;
    if ({b_out_valid, b_out_imm, b_out_fmt, b_out_illegal} !== {1'b1, 64'h0, 3'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL caddi_noc_b: got v=%b imm=%h fmt=%0d ill=%b want 1 0 0 1",
               b_out_valid, b_out_imm, b_out_fmt, b_out_illegal);
    end
    drive(1'b1, 32'h00000000, 1'b1, 1'b0);
    in_valid = 1'b0;
    tests_run++;
    if ({a_out_valid, a_out_imm, a_out_fmt, a_out_illegal, a_out_is_c} !==
        {1'b1, 32'h0, 3'd0, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL czero_a: got v=%b imm=%h fmt=%0d ill=%b c=%b want 1 0 0 1 1",
               a_out_valid, a_out_imm, a_out_fmt, a_out_illegal, a_out_is_c);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    $display("[TB] rvc c.addi and zero word checked");
  endtask

  task automatic test_shamt;
    drive(1'b1, 32'h02009093, 1'b1, 1'b0);
    in_valid = 1'b0;
    tests_run++;
    if ({a_out_valid, a_out_imm, a_out_fmt, a_out_illegal} !== {1'b1, 32'h0, 3'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL shamt32: got v=%b imm=%h fmt=%0d ill=%b want 1 0 0 1",
               a_out_valid, a_out_imm, a_out_fmt, a_out_illegal);
    end
    tests_run++;
    if ({b_out_valid, b_out_imm, b_out_fmt, b_out_illegal} !== {1'b1, 64'd32, 3'd6, 1'b0}) begin
      tests_failed++;
      $display("FAIL shamt64: got v=%b imm=%h fmt=%0d ill=%b want 1 20 6 0",
               b_out_valid, b_out_imm, b_out_fmt, b_out_illegal);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    $display("[TB] shamt instr[25]=1 checked on both widths");
  endtask

  task automatic test_flush;
    drive(1'b1, 32'hFFF00093, 1'b0, 1'b0);
    drive(1'b1, 32'hFE112E23, 1'b0, 1'b0);
    drive(1'b1, 32'h00500093, 1'b0, 1'b1);
    in_valid = 1'b0;
    flush    = 1'b0;
    tests_run++;
    if ({a_out_valid, a_in_ready, a_out_imm, b_out_valid} !== {1'b0, 1'b1, 32'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL flush_empty: got v=%b rdy=%b imm=%h vb=%b want 0 1 0 0",
               a_out_valid, a_in_ready, a_out_imm, b_out_valid);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tests_run++;
    if (a_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_drop: got v=%b want 0", a_out_valid);
    end
    $display("[TB] flush dropped buffered and offered entries");
  endtask

  task automatic test_async_reset;
    drive(1'b1, 32'hFFF00093, 1'b0, 1'b0);
    drive(1'b1, 32'hFF9FF06F, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({a_out_valid, a_in_ready, a_out_imm, a_out_fmt, a_out_illegal, a_out_is_c} !==
        {1'b0, 1'b1, 32'h0, 3'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL async_reset_a: got v=%b rdy=%b imm=%h fmt=%0d ill=%b c=%b want 0 1 0 0 0 0",
               a_out_valid, a_in_ready, a_out_imm, a_out_fmt, a_out_illegal, a_out_is_c);
    end
    tests_run++;
    if ({b_out_valid, b_in_ready, b_out_imm} !== {1'b0, 1'b1, 64'h0}) begin
      tests_failed++;
      $display("FAIL async_reset_b: got v=%b rdy=%b imm=%h want 0 1 0",
               b_out_valid, b_in_ready, b_out_imm);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    $display("[TB] asynchronous reset cleared the stage");
  endtask

  task automatic test_random;
    logic [31:0] q[$];
    logic [63:0] e_imm;
    logic [2:0]  e_fmt;
    bit          e_ill, e_c;
    bit          v, rdy, fl, do_push, do_pop;
    logic [31:0] ins;
    for (int it = 0; it < 400; it++) begin
      tests_run++;
      if ({a_out_valid, a_in_ready, b_out_valid, b_in_ready} !==
          {q.size() != 0, q.size() != 2, q.size() != 0, q.size() != 2}) begin
        tests_failed++;
        $display("FAIL rand_hs[%0d]: got va=%b ra=%b vb=%b rb=%b want occupancy %0d",
                 it, a_out_valid, a_in_ready, b_out_valid, b_in_ready, q.size());
      end
      if (q.size() != 0) begin
        ref_decode(q[0], 32, 1'b1, e_imm, e_fmt, e_ill, e_c);
        tests_run++;
        if ({a_out_imm, a_out_fmt, a_out_illegal, a_out_is_c} !== {e_imm[31:0], e_fmt, e_ill, e_c}) begin
          tests_failed++;
          $display("FAIL rand_a[%0d] instr=%h: got imm=%h fmt=%0d ill=%b c=%b want %h %0d %b %b",
                   it, q[0], a_out_imm, a_out_fmt, a_out_illegal, a_out_is_c,
                   e_imm[31:0], e_fmt, e_ill, e_c);
        end
        ref_decode(q[0], 64, 1'b0, e_imm, e_fmt, e_ill, e_c);
        tests_run++;
        if ({b_out_imm, b_out_fmt, b_out_illegal} !== {e_imm, e_fmt, e_ill}) begin
          tests_failed++;
          $display("FAIL rand_b[%0d] instr=%h: got imm=%h fmt=%0d ill=%b want %h %0d %b",
                   it, q[0], b_out_imm, b_out_fmt, b_out_illegal, e_imm, e_fmt, e_ill);
        end
      end else begin
        tests_run++;
        if ({a_out_imm, a_out_fmt, a_out_illegal, a_out_is_c, b_out_imm} !== 72'h0) begin
          tests_failed++;
          $display("FAIL rand_idle[%0d]: got a_imm=%h fmt=%0d ill=%b c=%b b_imm=%h want all 0",
                   it, a_out_imm, a_out_fmt, a_out_illegal, a_out_is_c, b_out_imm);
        end
      end
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 29) == 0);
      ins = gen_instr();
      if (fl) begin
        q.delete();
        $display("[TB] flush");
      end else begin
        do_pop  = (q.size() != 0) && rdy;
        do_push = v && (q.size() != 2);
        if (do_pop) begin
          $display("[TB] pop instr=%h fmt_a=%0d imm_a=%h imm_b=%h",
                   q[0], a_out_fmt, a_out_imm, b_out_imm);
          void'(q.pop_front());
        end
        if (do_push) q.push_back(ins);
      end
      drive(v, ins, rdy, fl);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_store_jump();
    test_backpressure();
    test_rvc();
    test_shamt();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
